// File: rtl/vector_mem_pkg.sv
// Shared types and constants for the vector load/store path.
// Latency: n/a (types, constants and a combinational range-check helper only).
// Backpressure: n/a.
package vector_mem_pkg;

  localparam int LANES       = 8;      // elements per beat
  localparam int ELEM_W      = 8;      // bits per element
  localparam int ADDR_W      = 20;     // byte address width
  localparam int BEAT_STRIDE = 64;     // bytes between consecutive beats
  localparam int LANE_STRIDE = 8;      // bytes between lanes of one beat
  localparam int MEM_DEPTH   = 36864;  // valid byte addresses 0..MEM_DEPTH-1

  // Lane 0 occupies the least significant element.
  typedef logic [LANES-1:0][ELEM_W-1:0] vec_t;

  // One extra bit so the end-of-transfer sum can never wrap.
  typedef logic [ADDR_W:0] ext_addr_t;

  typedef enum logic {
    OP_LOAD  = 1'b0,
    OP_STORE = 1'b1
  } lsu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_STORE = 2'd2
  } lsu_state_e;

  // True when the last lane of the last beat still lies inside memory.
  function automatic logic in_range(input logic [ADDR_W-1:0] base,
                                    input logic [3:0]        beats_m1);
    ext_addr_t last_byte;
    last_byte = ext_addr_t'(base)
              + ext_addr_t'(beats_m1) * ext_addr_t'(BEAT_STRIDE)
              + ext_addr_t'((LANES - 1) * LANE_STRIDE);
    return last_byte < ext_addr_t'(MEM_DEPTH);
  endfunction

endpackage

// File: rtl/vector_lsu_if.sv
// Bundle of the request, store-data, load-data and memory-port signals of the LSU.
// Latency: n/a (wiring only).
// Backpressure: req/st/ld use valid-ready; the memory port has none.
// Ports: master = requester + memory model side, slave = vector_lsu side.
interface vector_lsu_if;
  import vector_mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  lsu_op_e           req_op;
  logic [ADDR_W-1:0] req_base;
  logic [3:0]        req_beats;   // beat count minus one

  logic              st_valid;
  logic              st_ready;
  vec_t              st_data;

  logic              ld_valid;
  logic              ld_ready;
  vec_t              ld_data;
  logic              ld_last;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  vec_t              mem_wd;
  vec_t              mem_rd;

  logic              busy;
  logic              err;

  modport master (
    output req_valid, req_op, req_base, req_beats,
    output st_valid, st_data, ld_ready, mem_rd,
    input  req_ready, st_ready, ld_valid, ld_data, ld_last,
    input  mem_addr, mem_we, mem_wd, busy, err
  );

  modport slave (
    input  req_valid, req_op, req_base, req_beats,
    input  st_valid, st_data, ld_ready, mem_rd,
    output req_ready, st_ready, ld_valid, ld_data, ld_last,
    output mem_addr, mem_we, mem_wd, busy, err
  );

endinterface

// File: rtl/vector_addr_gen.sv
// Beat counter and address generator for one vector transfer.
// Latency: addr/is_last are combinational from the registered base, last and beat.
// Backpressure: the counter only moves on advance, so a stalled beat keeps its address.
// Ports: load latches base/last and zeroes the beat; advance steps the beat;
//        clear zeroes the beat; addr = base + beat*BEAT_STRIDE; is_last = (beat == last).
module vector_addr_gen
  import vector_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic              clear,
  input  logic [ADDR_W-1:0] base_in,
  input  logic [3:0]        last_in,
  output logic [ADDR_W-1:0] addr,
  output logic              is_last
);

  logic [ADDR_W-1:0] base_q;
  logic [3:0]        last_q;
  logic [3:0]        beat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q <= '0;
      last_q <= '0;
      beat_q <= '0;
    end else if (clear) begin
      beat_q <= '0;
    end else if (load) begin
      base_q <= base_in;
      last_q <= last_in;
      beat_q <= '0;
    end else if (advance) begin
      beat_q <= beat_q + 4'd1;
    end
  end

  assign addr    = base_q + ADDR_W'(beat_q) * ADDR_W'(BEAT_STRIDE);
  assign is_last = (beat_q == last_q);

endmodule

// File: rtl/vector_lsu.sv
// Vector load/store sequencer: one request becomes 1..16 eight-lane memory beats.
// Latency: load beat 0 appears on ld_* one cycle after acceptance; stores write in the handshake cycle.
// Backpressure: ld_ready low holds the address and the registered beat; st_valid low inserts bubbles.
// Ports: clk, rst (synchronous, active high); bus = vector_lsu_if.slave carrying the
//        request, store stream, load stream, memory port, busy and err.
module vector_lsu
  import vector_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  vector_lsu_if.slave bus
);

  lsu_state_e        state_q, state_d;
  logic              ld_valid_q, ld_last_q, err_q;
  vec_t              ld_data_q;

  logic              req_rdy, req_fire, req_ok;
  logic              ld_cap, st_fire;
  logic              ag_load, ag_adv, ag_clear;
  logic [ADDR_W-1:0] gen_addr;
  logic              is_last;

  // A pending load beat blocks new requests so ld_* never mixes two transfers.
  assign req_rdy  = (state_q == S_IDLE) && !ld_valid_q;
  assign req_fire = bus.req_valid && req_rdy;
  assign req_ok   = in_range(bus.req_base, bus.req_beats);
  assign ld_cap   = (state_q == S_LOAD) && (!ld_valid_q || bus.ld_ready);
  assign st_fire  = (state_q == S_STORE) && bus.st_valid;

  vector_addr_gen u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (ag_load),
    .advance (ag_adv),
    .clear   (ag_clear),
    .base_in (bus.req_base),
    .last_in (bus.req_beats),
    .addr    (gen_addr),
    .is_last (is_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_fire && req_ok)
                 state_d = (bus.req_op == OP_STORE) ? S_STORE : S_LOAD;
      S_LOAD:  if (ld_cap && is_last)  state_d = S_IDLE;
      S_STORE: if (st_fire && is_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = 1'b0;
    bus.st_ready  = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wd    = bus.st_data;
    bus.busy      = 1'b0;
    ag_load       = 1'b0;
    ag_adv        = 1'b0;
    ag_clear      = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.req_ready = req_rdy;
        ag_load       = req_fire && req_ok;
      end
      S_LOAD: begin
        bus.mem_addr = gen_addr;
        bus.busy     = 1'b1;
        ag_adv       = ld_cap && !is_last;
        ag_clear     = ld_cap && is_last;
      end
      S_STORE: begin
        bus.mem_addr = gen_addr;
        bus.busy     = 1'b1;
        bus.st_ready = 1'b1;
        // Reset must stop the write in the very cycle it is asserted.
        bus.mem_we   = bus.st_valid && !rst;
        ag_adv       = st_fire && !is_last;
        ag_clear     = st_fire && is_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_valid_q <= 1'b0;
      ld_last_q  <= 1'b0;
      ld_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= req_fire && !req_ok;
      if (ld_cap) begin
        ld_data_q  <= bus.mem_rd;
        ld_valid_q <= 1'b1;
        ld_last_q  <= is_last;
      end else if (bus.ld_ready) begin
        ld_valid_q <= 1'b0;
      end
    end
  end

  assign bus.ld_valid = ld_valid_q;
  assign bus.ld_data  = ld_data_q;
  assign bus.ld_last  = ld_last_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_vector_lsu.sv
// Self-checking bench for vector_lsu: directed scenarios followed by random traffic.
// Expected load beats and memory writes are queued at issue time from a reference memory
// and popped by an independent monitor whenever the DUT presents a beat or a write.
module tb_vector_lsu;
  import vector_mem_pkg::*;

  typedef struct { vec_t data; logic last; } ld_exp_t;
  typedef struct { int addr; vec_t data; }   wr_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vector_lsu_if bus ();
  vector_lsu dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [7:0] mem     [MEM_DEPTH];
  logic [7:0] ref_mem [MEM_DEPTH];
  ld_exp_t ld_q[$];
  wr_exp_t wr_q[$];

  int n_checks = 0, n_fail = 0;
  int we_cnt = 0, err_cnt = 0, exp_err = 0, ld_hs = 0;
  int sync_req = 0, sync_ack = 0;
  int rdy_mode = 0;  // 0: ld_ready high, 1: low, 2: random

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory model: write on the falling edge, then present read data for the next rising edge.
  always @(negedge clk) begin : memory_model
    vec_t rd;
    if (sync_req != sync_ack) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] = ref_mem[i];
      sync_ack = sync_req;
    end
    if (bus.mem_we === 1'b1)
      for (int k = 0; k < LANES; k++)
        if (int'(bus.mem_addr) + LANE_STRIDE * k < MEM_DEPTH)
          mem[int'(bus.mem_addr) + LANE_STRIDE * k] = bus.mem_wd[k];
    for (int k = 0; k < LANES; k++)
      rd[k] = (int'(bus.mem_addr) + LANE_STRIDE * k < MEM_DEPTH) ?
              mem[int'(bus.mem_addr) + LANE_STRIDE * k] : 8'h00;
    bus.mem_rd = rd;
  end

  // Monitor / scoreboard
  always @(negedge clk) begin : monitor
    ld_exp_t e;
    wr_exp_t w;
    if (bus.err === 1'b1) err_cnt++;
    if (bus.ld_valid === 1'b1 && bus.ld_ready === 1'b1) begin
      ld_hs++;
      if (ld_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL ld_extra: unexpected load beat %0h", bus.ld_data);
      end else begin
        e = ld_q.pop_front();
        chk("ld_data", bus.ld_data, e.data);
        chk("ld_last", 64'(bus.ld_last), 64'(e.last));
      end
    end
    if (bus.mem_we === 1'b1) begin
      we_cnt++;
      if (wr_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL wr_extra: unexpected write at %0h", bus.mem_addr);
      end else begin
        w = wr_q.pop_front();
        chk("wr_addr", 64'(bus.mem_addr), 64'(w.addr));
        chk("wr_data", bus.mem_wd, w.data);
      end
    end
  end

  initial begin : ready_driver
    bus.ld_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (rdy_mode)
        0:       bus.ld_ready = 1'b1;
        1:       bus.ld_ready = 1'b0;
        default: bus.ld_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Reference model: a transfer is legal when its last lane is inside memory.
  function automatic bit fits(input int base, input int m);
    return base + m * BEAT_STRIDE + (LANES - 1) * LANE_STRIDE < MEM_DEPTH;
  endfunction

  function automatic vec_t ref_beat(input int a);
    vec_t v;
    for (int k = 0; k < LANES; k++) v[k] = ref_mem[a + LANE_STRIDE * k];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_load(input int base, input int m);
    if (fits(base, m)) begin
      for (int b = 0; b <= m; b++)
        ld_q.push_back('{data: ref_beat(base + BEAT_STRIDE * b), last: (b == m)});
    end else exp_err++;
  endtask

  // Returns one time unit after the edge that accepted the request.
  task automatic issue(input lsu_op_e op, input int base, input int m);
    int t = 0;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_base  = ADDR_W'(base);
    bus.req_beats = 4'(m);
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && t < 400) begin @(negedge clk); t++; end
    if (bus.req_ready !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL req_timeout: req_ready=%b after %0d cycles", bus.req_ready, t);
    end
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic run_load(input int base, input int m);
    push_load(base, m);
    issue(OP_LOAD, base, m);
  endtask

  // gap_mode >= 0: fixed bubble before every beat after the first; < 0: random bubbles.
  task automatic run_store(input int base, input int m, input int gap_mode);
    vec_t d [16];
    bit ok;
    int g, t;
    ok = fits(base, m);
    for (int b = 0; b <= m; b++)
      for (int k = 0; k < LANES; k++) d[b][k] = 8'($urandom);
    if (ok) begin
      for (int b = 0; b <= m; b++) begin
        wr_q.push_back('{addr: base + BEAT_STRIDE * b, data: d[b]});
        for (int k = 0; k < LANES; k++) ref_mem[base + BEAT_STRIDE * b + LANE_STRIDE * k] = d[b][k];
      end
    end else exp_err++;
    issue(OP_STORE, base, m);
    if (!ok) return;
    for (int b = 0; b <= m; b++) begin
      g = (gap_mode >= 0) ? ((b == 0) ? 0 : gap_mode) : $urandom_range(0, 2);
      repeat (g) tick();
      bus.st_valid = 1'b1;
      bus.st_data  = d[b];
      t = 0;
      @(negedge clk);
      while (bus.st_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
      if (bus.st_ready !== 1'b1) begin
        n_checks++; n_fail++;
        $display("FAIL st_timeout: st_ready=%b on beat %0d", bus.st_ready, b);
      end
      tick();
      bus.st_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((ld_q.size() != 0 || wr_q.size() != 0 || bus.req_ready !== 1'b1) && t < 1000) begin
      @(negedge clk); t++;
    end
    chk("drain_pending", 64'(ld_q.size() + wr_q.size()), 64'd0);
    chk("drain_req_ready", 64'(bus.req_ready), 64'd1);
    tick();
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int w0, e0, low, h0, mism, m, base, maxb;
    vec_t sd [4];
    bus.req_valid = 1'b0;
    bus.req_op    = OP_LOAD;
    bus.req_base  = '0;
    bus.req_beats = '0;
    bus.st_valid  = 1'b0;
    bus.st_data   = '0;

    for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = 8'($urandom);
    for (int k = 0; k < LANES; k++) ref_mem[32'h100 + LANE_STRIDE * k] = 8'(k + 1);
    sync_req++;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_ld_valid",  64'(bus.ld_valid),  64'd0);
    chk("rst_ld_data",   bus.ld_data,        64'd0);
    chk("rst_ld_last",   64'(bus.ld_last),   64'd0);
    chk("rst_err",       64'(bus.err),       64'd0);
    chk("rst_busy",      64'(bus.busy),      64'd0);
    chk("rst_mem_addr",  64'(bus.mem_addr),  64'd0);
    chk("rst_mem_we",    64'(bus.mem_we),    64'd0);
    chk("rst_st_ready",  64'(bus.st_ready),  64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Single-beat load: latency and lane order
    run_load(32'h100, 0);
    @(negedge clk);
    chk("ld1_addr",      64'(bus.mem_addr), 64'h100);
    chk("ld1_busy",      64'(bus.busy),     64'd1);
    chk("ld1_early_vld", 64'(bus.ld_valid), 64'd0);
    @(negedge clk);
    chk("ld1_valid",     64'(bus.ld_valid), 64'd1);
    chk("ld1_data_const", bus.ld_data,      64'h0807060504030201);
    chk("ld1_last",      64'(bus.ld_last),  64'd1);
    @(negedge clk);
    chk("ld1_req_ready", 64'(bus.req_ready), 64'd1);
    tick();

    // Four-beat load with a three-cycle stall after the first beat
    run_load(0, 3);
    tick();
    tick();
    rdy_mode = 1;
    @(negedge clk);
    chk("stall_addr_a", 64'(bus.mem_addr), 64'd128);
    tick();
    tick();
    @(negedge clk);
    chk("stall_addr_b",  64'(bus.mem_addr), 64'd128);
    chk("stall_ld_valid", 64'(bus.ld_valid), 64'd1);
    tick();
    rdy_mode = 0;
    wait_drain();

    // Two-beat store with a two-cycle bubble
    w0 = we_cnt;
    run_store(32'h200, 1, 2);
    wait_drain();
    chk("st2_we_cycles", 64'(we_cnt - w0), 64'd2);
    mism = 0;
    for (int a = 32'h200; a < 32'h280; a++) if (mem[a] !== ref_mem[a]) mism++;
    chk("st2_mem", 64'(mism), 64'd0);

    // Range limits
    w0 = we_cnt;
    run_load(36800, 0);
    wait_drain();
    e0 = err_cnt;
    push_load(36808, 0);
    issue(OP_LOAD, 36808, 0);
    @(negedge clk);
    chk("rng_err",       64'(bus.err),       64'd1);
    chk("rng_busy",      64'(bus.busy),      64'd0);
    chk("rng_req_ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    chk("rng_err_pulse", 64'(bus.err),       64'd0);
    chk("rng_no_write",  64'(we_cnt - w0),   64'd0);
    chk("rng_err_count", 64'(err_cnt - e0),  64'd1);
    tick();

    // Reset during beat 2 of a four-beat store
    w0 = we_cnt;
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < LANES; k++) sd[b][k] = 8'($urandom);
    for (int b = 0; b < 2; b++) begin
      wr_q.push_back('{addr: 32'h300 + BEAT_STRIDE * b, data: sd[b]});
      for (int k = 0; k < LANES; k++) ref_mem[32'h300 + BEAT_STRIDE * b + LANE_STRIDE * k] = sd[b][k];
    end
    issue(OP_STORE, 32'h300, 3);
    bus.st_valid = 1'b1;
    bus.st_data  = sd[0];
    tick();
    bus.st_data  = sd[1];
    tick();
    bus.st_data  = sd[2];
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_we", 64'(bus.mem_we), 64'd0);
    tick();
    rst = 1'b0;
    bus.st_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_busy",     64'(bus.busy),      64'd0);
    chk("rstmid_addr",     64'(bus.mem_addr),  64'd0);
    chk("rstmid_st_ready", 64'(bus.st_ready),  64'd0);
    chk("rstmid_ld_valid", 64'(bus.ld_valid),  64'd0);
    chk("rstmid_req_rdy",  64'(bus.req_ready), 64'd1);
    chk("rstmid_writes",   64'(we_cnt - w0),   64'd2);
    mism = 0;
    for (int a = 32'h300; a < 32'h400; a++) if (mem[a] !== ref_mem[a]) mism++;
    chk("rstmid_mem", 64'(mism), 64'd0);
    tick();

    // Sixteen-beat load with the next request already waiting
    push_load(32'h1000, 15);
    issue(OP_LOAD, 32'h1000, 15);
    bus.req_valid = 1'b1;
    bus.req_base  = ADDR_W'(32'h2000);
    bus.req_beats = 4'd2;
    push_load(32'h2000, 2);
    h0 = ld_hs;
    low = 0;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && low < 100) begin low++; @(negedge clk); end
    chk("burst_busy_cycles", 64'(low), 64'd17);
    chk("burst_beats",       64'(ld_hs - h0), 64'd16);
    tick();
    bus.req_valid = 1'b0;
    wait_drain();

    // Random traffic
    rdy_mode = 2;
    for (int i = 0; i < 30; i++) begin
      m    = $urandom_range(0, 15);
      maxb = MEM_DEPTH - 1 - (LANES - 1) * LANE_STRIDE - BEAT_STRIDE * m;
      base = ($urandom_range(0, 5) == 0) ? $urandom_range(maxb + 1, (1 << ADDR_W) - 1)
                                         : $urandom_range(0, maxb);
      if ($urandom_range(0, 1) != 0) run_store(base, m, -1);
      else                           run_load(base, m);
    end
    wait_drain();
    rdy_mode = 0;
    repeat (2) tick();

    chk("err_total", 64'(err_cnt), 64'(exp_err));
    mism = 0;
    for (int a = 0; a < MEM_DEPTH; a++) if (mem[a] !== ref_mem[a]) mism++;
    chk("mem_final", 64'(mism), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_lsu.md
# vector_lsu

Vector load/store sequencer sitting directly upstream of the vector data memory in the CPU's memory stage. Accepts one load or store request (base address plus beat count), then issues one 8-lane memory beat per cycle. Beats advance by 64 bytes; lanes within a beat are 8 bytes apart. Load beats are returned through a registered valid/ready output, and store data is taken from a valid/ready input stream. Out-of-range requests are rejected before any memory access.

## Interface
- `LANES`, 8, elements per beat
- `ELEM_W`, 8, bits per element
- `ADDR_W`, 20, memory address width
- `BEAT_STRIDE`, 64, byte distance between consecutive beats
- `MEM_DEPTH`, 36864, valid byte addresses are 0..MEM_DEPTH-1
- `CLK` in 1: single clock
- `RST` in 1: synchronous, active-high reset
- `req_valid` in 1, `req_ready` out 1: request handshake
- `req_op` in 1: 0 = load, 1 = store
- `req_base` in ADDR_W: byte address of beat 0, lane 0
- `req_beats` in 4: beat count minus 1 (1..16 beats)
- `st_valid` in 1, `st_ready` out 1, `st_data` in LANES×ELEM_W: store beat stream
- `ld_valid` out 1, `ld_ready` in 1, `ld_data` out LANES×ELEM_W, `ld_last` out 1: load beat stream
- `mem_addr` out ADDR_W, `mem_we` out 1, `mem_wd` out LANES×ELEM_W, `mem_rd` in LANES×ELEM_W: memory port. Reads are combinational; memory writes on the falling edge while `mem_we`=1.
- `busy` out 1: state ≠ IDLE
- `err` out 1: one-cycle pulse on a rejected request

## Operation
- States: IDLE, LOAD, STORE.
- `req_ready` = (state==IDLE) && !ld_valid. A request is accepted on a rising edge with req_valid && req_ready.
- Range check at acceptance: end = req_base + req_beats·64 + 56, computed at ADDR_W+1 bits (no wrap).
  - If end ≥ MEM_DEPTH: `err`=1 for one cycle, request is consumed, state stays IDLE, no memory access.
- Otherwise latch the base, clear the beat counter, latch last = req_beats, and go to LOAD or STORE.
- `mem_addr` = base + beat·64 in LOAD/STORE; 0 in IDLE.
- LOAD:
  - Capture `mem_rd` into `ld_data` when !ld_valid || ld_ready. Then set ld_valid, set ld_last = (beat==last), and advance the beat.
  - After capturing the last beat, go to IDLE. ld_valid stays high until consumed.
  - ld_valid drops on ld_ready with no new capture.
- STORE:
  - `st_ready`=1 and `mem_we` = st_valid, with `mem_wd` = st_data.
  - Each handshake advances the beat. After the last beat, go to IDLE.
  - In all other states `st_ready`=0.
- `mem_we` is forced to 0 whenever RST=1 or state≠STORE.
- Reset mid-operation: the transfer is abandoned. Beats already written remain in memory; no further beats are written.
- Reset values: state IDLE, ld_valid 0, ld_data 0, ld_last 0, err 0, busy 0, beat counter 0, mem_addr 0, mem_we 0.

## Timing
- Load latency: accept at edge E0; mem_addr = base during E0→E1; ld_valid = 1 with beat 0 after E1.
- Loads sustain 1 beat/cycle while ld_ready=1. When ld_ready=0 with ld_valid=1, mem_addr holds and no beat is lost.
- Stores sustain 1 beat/cycle while st_valid=1. Bubbles are allowed; mem_addr holds through a bubble.
- Capture and drain in the same cycle is legal and keeps full throughput.
- err is asserted in the cycle after the rejecting edge. req_ready is high again in that same cycle.

## Structure
- Package `vector_mem_pkg` holds:
  - LANES, ELEM_W, ADDR_W, BEAT_STRIDE, LANE_STRIDE (=8), MEM_DEPTH
  - `vec_t` (packed LANES×ELEM_W)
  - `lsu_op_e` (LOAD, STORE)
  - `lsu_state_e`
- Sub-module `vector_addr_gen` contains the beat counter, address adder and last-beat flag, with load/advance/clear inputs.

## Test plan
- Load, 1 beat, base 0x00100, memory[0x100+8k] = k+1 -> ld_valid one cycle after accept; ld_data lanes 0..7 = 01..08; ld_last=1; req_ready returns once drained.
- Load, 4 beats, base 0, ld_ready low for 3 cycles after the first beat -> beats from 0, 64, 128, 192 in order, none duplicated or lost; ld_last only on beat 3.
- Store, 2 beats, base 0x00200, st_valid with a 2-cycle gap -> mem_we high exactly 2 cycles; 0x200..0x238 and 0x240..0x278 hold the sent lanes.
- Range check: base 36800 with 1 beat is accepted (end 36856); base 36808 with 1 beat -> err pulse, mem_we never asserted, busy stays 0.
- RST asserted during beat 2 of a 4-beat store -> mem_we=0 in that cycle, all outputs at reset values next cycle, only beats 0–1 are in memory.
- req_valid held during a 16-beat load with ld_ready=1 -> 16 consecutive beats; req_ready stays low until the last ld handshake, then the second request is accepted.
